cpu_wb_master: RTL

Wishbone B3 classic-cycle master that executes single read/write commands issued by the PC-link packet decoder over the `cpu_*` command bus. It sits directly downstream of the UART/packet-decode front end and directly upstream of the system Wishbone interconnect, and returns read data and busy status to the decoder. A bus-timeout watchdog guarantees every command terminates.

---
 rtl/pc_interface_pkg.sv | 18 +
 rtl/cpu_wb_master.sv | 123 ++++++++++++
 2 files changed

// File: rtl/pc_interface_pkg.sv
// -----------------------------------------------------------------------------
// pc_interface_pkg
//   Definitions shared between the PC-link packet decoder and the Wishbone
//   command master: the master's state encoding and the default data word
//   returned on a failed read, which the decoder also uses in error replies.
// -----------------------------------------------------------------------------
package pc_interface_pkg;

  // IDLE waits for a command strobe; BUS holds one classic Wishbone cycle.
  typedef enum logic {
    IDLE = 1'b0,
    BUS  = 1'b1
  } wb_state_t;

  // Read data reported when a bus cycle ends in error or times out.
  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

endpackage : pc_interface_pkg

// File: rtl/cpu_wb_master.sv
// -----------------------------------------------------------------------------
// cpu_wb_master
//   Wishbone B3 classic-cycle master executing single read/write commands from
//   the packet decoder. A watchdog aborts any cycle the slave never answers.
//
// Parameters
//   dw        data width (32 only)
//   aw        address width
//   TIMEOUT   strobe cycles without ack/err before abort; 0 disables watchdog
//   ERR_DATA  read data reported after err or timeout
//
// Ports
//   wb_clk, wb_rst      clock (rising edge), async active-low reset
//   cpu_start           one-cycle command strobe (ignored while busy)
//   cpu_address/_selection/_write/_data_wr   command fields
//   cpu_data_rd         last completed read data (held)
//   cpu_active          command in flight
//   cpu_error           last command ended in err or timeout
//   wb_*_o / wb_*_i     Wishbone master interface
// -----------------------------------------------------------------------------
module cpu_wb_master
  import pc_interface_pkg::*;
#(
  parameter int              dw       = 32,
  parameter int              aw       = 32,
  parameter int              TIMEOUT  = 255,
  parameter logic [dw-1:0]   ERR_DATA = ERR_DATA_DEFAULT
) (
  input  logic          wb_clk,
  input  logic          wb_rst,
  input  logic          cpu_start,
  input  logic [aw-1:0] cpu_address,
  input  logic [3:0]    cpu_selection,
  input  logic          cpu_write,
  input  logic [dw-1:0] cpu_data_wr,
  output logic [dw-1:0] cpu_data_rd,
  output logic          cpu_active,
  output logic          cpu_error,
  output logic [aw-1:0] wb_adr_o,
  output logic [dw-1:0] wb_dat_o,
  output logic [3:0]    wb_sel_o,
  output logic          wb_we_o,
  output logic          wb_cyc_o,
  output logic          wb_stb_o,
  input  logic [dw-1:0] wb_dat_i,
  input  logic          wb_ack_i,
  input  logic          wb_err_i
);

  // A zero TIMEOUT still needs a legal (1-bit) counter even though it is unused.
  localparam int            CW   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TLIM = CW'(TIMEOUT);
  localparam logic [CW-1:0] TMAX = {CW{1'b1}};

  wb_state_t     state;
  logic [CW-1:0] tcnt;
  logic [CW-1:0] tcnt_inc;
  logic          timeout_hit;

  // Counter value including the BUS cycle being sampled at this edge, so the
  // abort lands exactly on the TIMEOUT-th strobe cycle.
  assign tcnt_inc    = (tcnt == TMAX) ? tcnt : tcnt + CW'(1);
  assign timeout_hit = (TIMEOUT != 0) && (tcnt_inc == TLIM);

  // The Wishbone outputs double as the command registers: they are loaded only
  // on accept, so decoder-side changes during BUS never reach the bus.
  always_ff @(posedge wb_clk or negedge wb_rst) begin
    if (!wb_rst) begin
      state       <= IDLE;
      tcnt        <= '0;
      wb_adr_o    <= '0;
      wb_dat_o    <= '0;
      wb_sel_o    <= '0;
      wb_we_o     <= 1'b0;
      wb_cyc_o    <= 1'b0;
      wb_stb_o    <= 1'b0;
      cpu_active  <= 1'b0;
      cpu_error   <= 1'b0;
      cpu_data_rd <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register reading the values
      // from before this edge, so statement order here does not matter.
      unique case (state)
        IDLE: begin
          if (cpu_start) begin
            wb_adr_o   <= cpu_address;
            wb_dat_o   <= cpu_data_wr;
            wb_sel_o   <= cpu_selection;
            wb_we_o    <= cpu_write;
            wb_cyc_o   <= 1'b1;
            wb_stb_o   <= 1'b1;
            cpu_active <= 1'b1;
            cpu_error  <= 1'b0;
            tcnt       <= '0;
            state      <= BUS;
          end
        end

        BUS: begin
          if (wb_err_i || wb_ack_i || timeout_hit) begin
            wb_cyc_o   <= 1'b0;
            wb_stb_o   <= 1'b0;
            cpu_active <= 1'b0;
            state      <= IDLE;
            // err outranks a simultaneous ack; timeout only applies when silent.
            if (wb_err_i || !wb_ack_i) begin
              cpu_error <= 1'b1;
              if (!wb_we_o) cpu_data_rd <= ERR_DATA;
            end else begin
              cpu_error <= 1'b0;
              if (!wb_we_o) cpu_data_rd <= wb_dat_i;
            end
          end else begin
            tcnt <= tcnt_inc;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule : cpu_wb_master
